// File: rtl/alu_mdu_control.sv
// ALU control decode plus an iterative multiply/divide unit with HI/LO
// registers. Multiply is shift-add, divide is restoring shift-subtract,
// both on operand magnitudes with a one-cycle sign fix-up at the end.
module alu_mdu_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Aluop,
    input  logic [5:0]       funct,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       Alucontrol,
    output logic             mdu_sel,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             busy,
    output logic             stall
);

    localparam int DW = 2 * WIDTH;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic               isDiv_q, isDiv_d;
    logic               negLo_q, negLo_d;
    logic               negHi_q, negHi_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               cmd;
    logic               isStartOp;
    logic               isDivFn;
    logic               isSignedFn;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [DW-1:0]      mulNext;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [DW-1:0]      divNext;
    logic [DW-1:0]      prodFixed;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // ALU operation code from Aluop, and funct for R-type
    always_comb begin
        Alucontrol = 4'b0000;
        case (Aluop)
            2'b00: Alucontrol = 4'b0010;
            2'b01: Alucontrol = 4'b0110;
            2'b10: begin
                case (funct)
                    F_ADD:   Alucontrol = 4'b0010;
                    F_SUB:   Alucontrol = 4'b0110;
                    F_AND:   Alucontrol = 4'b0000;
                    F_OR:    Alucontrol = 4'b0001;
                    F_XOR:   Alucontrol = 4'b0011;
                    F_NOR:   Alucontrol = 4'b1100;
                    F_SLT:   Alucontrol = 4'b0111;
                    default: Alucontrol = 4'b0000;
                endcase
            end
            default: Alucontrol = 4'b0000;
        endcase
    end

    // Flag R-type functs that belong to the multiply/divide unit
    always_comb begin
        mdu_sel = 1'b0;
        if (Aluop == 2'b10) begin
            case (funct)
                F_MULT, F_MULTU, F_DIV, F_DIVU,
                F_MFHI, F_MFLO, F_MTHI, F_MTLO: mdu_sel = 1'b1;
                default:                        mdu_sel = 1'b0;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = in_valid & mdu_sel & busy;
    assign cmd   = in_valid & mdu_sel & ~stall;

    assign isStartOp  = (funct == F_MULT) || (funct == F_MULTU) ||
                        (funct == F_DIV)  || (funct == F_DIVU);
    assign isDivFn    = (funct == F_DIV)  || (funct == F_DIVU);
    assign isSignedFn = (funct == F_MULT) || (funct == F_DIV);

    assign absA = src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
    assign absB = src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;

    // Multiply step: conditionally add multiplicand into the top half, then shift right
    assign mulSum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
    assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

    // Divide step: shift remainder:quotient left, keep the difference when it does not borrow
    assign divShift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opB_q};
    assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign prodFixed = negLo_q ? (~acc_q + DW'(1)) : acc_q;
    assign quot      = acc_q[WIDTH-1:0];
    assign rem       = acc_q[DW-1:WIDTH];

    // mfhi/mflo read out only when the command is actually accepted
    always_comb begin
        hilo_rdata = '0;
        if (cmd && funct == F_MFHI) begin
            hilo_rdata = hi_q;
        end else if (cmd && funct == F_MFLO) begin
            hilo_rdata = lo_q;
        end
    end

    // MDU next state: accept in IDLE, iterate in CALC, sign fix-up and HI/LO write in FIX
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        isDiv_d   = isDiv_q;
        negLo_d   = negLo_q;
        negHi_d   = negHi_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (cmd) begin
                    if (isStartOp) begin
                        state_d   = CALC;
                        cnt_d     = '0;
                        isDiv_d   = isDivFn;
                        acc_d     = {{WIDTH{1'b0}}, (isSignedFn ? absA : src_a)};
                        opB_d     = isSignedFn ? absB : src_b;
                        negLo_d   = isSignedFn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        negHi_d   = isDivFn ? (isSignedFn & src_a[WIDTH-1])
                                            : (isSignedFn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]));
                        divZero_d = (src_b == '0);
                    end else if (funct == F_MTHI) begin
                        hi_d = src_a;
                    end else if (funct == F_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            CALC: begin
                acc_d = isDiv_q ? divNext : mulNext;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = divZero_q ? '1 : (negLo_q ? (~quot + WIDTH'(1)) : quot);
                    hi_d = negHi_q ? (~rem + WIDTH'(1)) : rem;
                end else begin
                    hi_d = prodFixed[DW-1:WIDTH];
                    lo_d = prodFixed[WIDTH-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // MDU state and HI/LO registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            isDiv_q   <= isDiv_d;
            negLo_q   <= negLo_d;
            negHi_q   <= negHi_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
